// File: rtl/spike_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spike_event_scheduler                                      |
// | Description : Time-stamped spike injector. Queued (time,row) events are  |
// |               issued as 1-cycle row pulses when the time base reaches    |
// |               them. Optional macro SPIKE_STATS_EN adds per-row counters. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spike_event_scheduler #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int ROW_WIDTH        = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    parameter int TIME_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic [TIME_WIDTH-1:0]         ev_time,
    input  logic [ROW_WIDTH-1:0]          ev_row,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
    output logic [NUM_SYNAPSE_ROWS-1:0]   spike_out,
    output logic [TIME_WIDTH-1:0]         now,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
`ifdef SPIKE_STATS_EN
    output logic [NUM_SYNAPSE_ROWS*16-1:0] stat_count,
`endif
    output logic                          order_err,
    output logic                          late_err
);

    localparam int                          c_aw        = $clog2(FIFO_DEPTH);
    localparam logic [TIME_WIDTH-1:0]       c_time_max  = {TIME_WIDTH{1'b1}};
    localparam logic [NUM_SYNAPSE_ROWS-1:0] c_row_base  = NUM_SYNAPSE_ROWS'(1);
    localparam logic [0:0]                  c_st_idle   = 1'b0;
    localparam logic [0:0]                  c_st_run    = 1'b1;

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic                        w_run;

    logic [TIME_WIDTH-1:0]       r_mem_time [FIFO_DEPTH];
    logic [ROW_WIDTH-1:0]        r_mem_row  [FIFO_DEPTH];
    logic [c_aw:0]               r_wr_ptr;
    logic [c_aw:0]               r_rd_ptr;
    logic [TIME_WIDTH-1:0]       r_now;
    logic [TIME_WIDTH-1:0]       r_last_time;
    logic [NUM_SYNAPSE_ROWS-1:0] r_spike;
    logic                        r_order_err;
    logic                        r_late_err;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_clear;
    logic                        w_handshake;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_pop;
    logic                        w_row_ok;
    logic                        w_pulse;
    logic [TIME_WIDTH-1:0]       w_head_time;
    logic [ROW_WIDTH-1:0]        w_head_row;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start && !stop) w_state_nxt = c_st_run;
            c_st_run:  if (stop)           w_state_nxt = c_st_idle;
            default:                       w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_run = 1'b0;
        case (r_state)
            c_st_run: w_run = 1'b1;
            default:  w_run = 1'b0;
        endcase
    end

    // ---------------- queue control ----------------
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                         (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_clear     = clear && !w_run;
    assign w_handshake = ev_valid && !w_full && !w_clear;
    assign w_push      = w_handshake && (ev_time >= r_last_time);
    assign w_drop      = w_handshake && (ev_time <  r_last_time);

    assign w_head_time = r_mem_time[r_rd_ptr[c_aw-1:0]];
    assign w_head_row  = r_mem_row[r_rd_ptr[c_aw-1:0]];

    // Emptiness is taken from registered pointers, so a push into an empty queue pops next cycle at the earliest.
    assign w_pop    = w_run && !w_empty && (w_head_time <= r_now);
    assign w_row_ok = (int'(w_head_row) < NUM_SYNAPSE_ROWS);
    assign w_pulse  = w_pop && w_row_ok;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr[c_aw-1:0]] <= ev_time;
            r_mem_row[r_wr_ptr[c_aw-1:0]]  <= ev_row;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_time <= '0;
        end else if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_time <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_last_time <= ev_time;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- time base, pulses, flags ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_now       <= '0;
            r_spike     <= '0;
            r_order_err <= 1'b0;
            r_late_err  <= 1'b0;
        end else begin
            r_spike <= w_pulse ? (c_row_base << w_head_row) : '0;
            if (w_clear) begin
                r_now       <= '0;
                r_order_err <= 1'b0;
                r_late_err  <= 1'b0;
            end else begin
                // Saturate rather than wrap so events at the top timestamp still issue once.
                if (w_run && tick && (r_now != c_time_max)) begin
                    r_now <= r_now + 1'b1;
                end
                if (w_drop) begin
                    r_order_err <= 1'b1;
                end
                if (w_pop && (w_head_time < r_now)) begin
                    r_late_err <= 1'b1;
                end
            end
        end
    end

`ifdef SPIKE_STATS_EN
    for (genvar g = 0; g < NUM_SYNAPSE_ROWS; g++) begin : g_stat
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (w_clear) begin
                r_cnt <= '0;
            end else if (w_pulse && (w_head_row == ROW_WIDTH'(g)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign stat_count[g*16 +: 16] = r_cnt;
    end
`endif

    assign ev_ready  = !w_full;
    assign spike_out = r_spike;
    assign now       = r_now;
    assign running   = w_run;
    assign fill      = r_wr_ptr - r_rd_ptr;
    assign order_err = r_order_err;
    assign late_err  = r_late_err;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spike_event_scheduler                                   |
// | Description : Scoreboard bench for spike_event_scheduler (4-bit time,    |
// |               3-bit row index over 2 rows, 16-deep queue).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spike_event_scheduler;

    localparam int c_rows = 2;
    localparam int c_rw   = 3;
    localparam int c_tw   = 4;
    localparam int c_dep  = 16;

    logic              clk;
    logic              reset_n;
    logic              ev_valid;
    logic              ev_ready;
    logic [c_tw-1:0]   ev_time;
    logic [c_rw-1:0]   ev_row;
    logic              tick;
    logic              start;
    logic              stop;
    logic              clear;
    logic [c_rows-1:0] spike_out;
    logic [c_tw-1:0]   now;
    logic              running;
    logic [4:0]        fill;
    logic              order_err;
    logic              late_err;
`ifdef SPIKE_STATS_EN
    logic [c_rows*16-1:0] stat_count;
`endif

    spike_event_scheduler #(
        .NUM_SYNAPSE_ROWS (c_rows),
        .ROW_WIDTH        (c_rw),
        .TIME_WIDTH       (c_tw),
        .FIFO_DEPTH       (c_dep)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_time    (ev_time),
        .ev_row     (ev_row),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .spike_out  (spike_out),
        .now        (now),
        .running    (running),
        .fill       (fill),
`ifdef SPIKE_STATS_EN
        .stat_count (stat_count),
`endif
        .order_err  (order_err),
        .late_err   (late_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int model_last = 0;
    logic [c_rows-1:0] exp_q[$];
    int seen_now[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every driven pulse must match the next expected row in push order.
    always @(negedge clk) begin
        if (reset_n && (spike_out != '0)) begin
            pulse_cnt++;
            seen_now.push_back(int'(now));
            if (exp_q.size() == 0) check_val("spurious_spike", 32'(spike_out), 32'd0);
            else                   check_val("spike_row", 32'(spike_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int t, input int r);
        logic [c_rows-1:0] oh;
        ev_valid = 1'b1;
        ev_time  = c_tw'(t);
        ev_row   = c_rw'(r);
        if (ev_ready && (t >= model_last)) begin
            model_last = t;
            if (r < c_rows) begin
                oh = c_rows'(1) << r;
                exp_q.push_back(oh);
            end
        end
        step(1);
        ev_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(1); clear = 1'b0;
        model_last = 0;
        exp_q.delete();
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int k = 0;
        while ((pulse_cnt < target) && (k < budget)) begin
            step(1);
            k++;
        end
        if (pulse_cnt < target) check_val("pulse_timeout", 32'(pulse_cnt), 32'(target));
    endtask

    initial begin
        int base;
        int k;
        reset_n = 1'b0; ev_valid = 1'b0; ev_time = '0; ev_row = '0;
        tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        step(3);
        check_val("rst_spike", 32'(spike_out), 0);
        check_val("rst_now", 32'(now), 0);
        check_val("rst_running", 32'(running), 0);
        check_val("rst_fill", 32'(fill), 0);
        check_val("rst_ready", 32'(ev_ready), 1);
        check_val("rst_flags", {30'd0, order_err, late_err}, 0);
        reset_n = 1'b1;
        step(1);

        // Basic issue, ordering of equal timestamps, late flag
        push_ev(5, 0); push_ev(5, 1); push_ev(9, 1);
        check_val("t1_fill", 32'(fill), 3);
        seen_now.delete();
        tick = 1'b1;
        pulse_start();
        check_val("t1_running", 32'(running), 1);
        check_val("t1_now0", 32'(now), 0);
        wait_pulses(3, 40);
        if (seen_now.size() >= 3) begin
            check_val("t1_now_p0", 32'(seen_now[0]), 6);
            check_val("t1_now_p1", 32'(seen_now[1]), 7);
            check_val("t1_now_p2", 32'(seen_now[2]), 10);
        end
        check_val("t1_late", 32'(late_err), 1);
        check_val("t1_order", 32'(order_err), 0);
        pulse_stop();
        check_val("t1_stopped", 32'(running), 0);
        do_clear();
        check_val("clr_now", 32'(now), 0);
        check_val("clr_fill", 32'(fill), 0);
        check_val("clr_flags", {30'd0, order_err, late_err}, 0);

        // Out-of-order push dropped
        tick = 1'b0;
        push_ev(10, 1); push_ev(4, 0);
        check_val("t2_fill", 32'(fill), 1);
        check_val("t2_order", 32'(order_err), 1);
        check_val("t2_ready", 32'(ev_ready), 1);
        do_clear();

        // Fill to capacity, frozen time base, stop/start resume, drain
        base = pulse_cnt;
        for (int i = 0; i < c_dep; i++) push_ev(i / 2, i % 4);
        check_val("t3_full_ready", 32'(ev_ready), 0);
        check_val("t3_full_fill", 32'(fill), 16);
        push_ev(8, 0);
        check_val("t3_ignored_fill", 32'(fill), 16);
        check_val("t3_ignored_order", 32'(order_err), 0);
        pulse_start();
        step(1);
        check_val("t3_ready_after_pop", 32'(ev_ready), 1);
        check_val("t3_fill_15", 32'(fill), 15);
        step(4);
        check_val("t3_frozen_now", 32'(now), 0);
        check_val("t3_frozen_fill", 32'(fill), 14);
        tick = 1'b1;
        step(3);
        check_val("t3_now3", 32'(now), 3);
        pulse_stop();
        step(3);
        check_val("t3_hold_now", 32'(now), 4);
        check_val("t3_hold_idle", 32'(running), 0);
        pulse_start();
        check_val("t3_resume_now", 32'(now), 4);
        k = 0;
        while ((fill != 0) && (k < 60)) begin step(1); k++; end
        check_val("t3_drain_fill", 32'(fill), 0);
        step(2);
        check_val("t3_pulses", 32'(pulse_cnt - base), 8);
        check_val("t3_late", 32'(late_err), 1);
        pulse_stop();
        do_clear();

        // Saturating time base
        base = pulse_cnt;
        seen_now.delete();
        push_ev(15, 0);
        pulse_start();
        step(40);
        check_val("t4_sat_now", 32'(now), 15);
        check_val("t4_pulses", 32'(pulse_cnt - base), 1);
        if (seen_now.size() >= 1) check_val("t4_pulse_now", 32'(seen_now[0]), 15);
        check_val("t4_late", 32'(late_err), 0);
        check_val("t4_fill", 32'(fill), 0);
        pulse_stop();
        do_clear();

        // Async reset right before a pulse would be registered
        base = pulse_cnt;
        push_ev(3, 1);
        pulse_start();
        step(3);
        check_val("t5_now3", 32'(now), 3);
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_running", 32'(running), 0);
        check_val("t5_rst_fill", 32'(fill), 0);
        check_val("t5_rst_now", 32'(now), 0);
        exp_q.delete();
        model_last = 0;
        step(2);
        check_val("t5_rst_spike", 32'(spike_out), 0);
        reset_n = 1'b1;
        step(3);
        check_val("t5_pulses", 32'(pulse_cnt - base), 0);

`ifdef SPIKE_STATS_EN
        tick = 1'b0;
        push_ev(0, 0); push_ev(0, 1); push_ev(0, 7);
        push_ev(0, 0); push_ev(0, 1); push_ev(0, 0);
        pulse_start();
        step(10);
        check_val("st_row0", 32'(stat_count[15:0]), 3);
        check_val("st_row1", 32'(stat_count[31:16]), 2);
        pulse_stop();
        do_clear();
        check_val("st_clr", stat_count, 0);
`endif

        step(2);
        check_val("end_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
